tap_read_arbiter: RTL and testbench
===================================

TAP_READ_ARBITER -- requirements
Module: tap_read_arbiter

Interface
REQ-001 SHALL have parameter READ_WIDTH, default 32, width of read data path.
REQ-002 SHALL have parameter MAX_RETRY, default 15, number of re-issues after a not-valid sample; the retry counter is $clog2(MAX_RETRY+1) bits, minimum 1.
REQ-003 SHALL use IRLENGTH, ADDR_NOP from uart_pkg for all address widths and the idle address.
REQ-004 SHALL have ports:
  CLK_I  in  1  sole clock, all logic on rising edge.
  RST_I  in  1  synchronous active-high reset.
  HOST_REQ_I  in  1  host read request, level.
  HOST_ADDR_I  in  IRLENGTH  host read address.
  HOST_ACK_O  out  1  one-cycle pulse, host request granted.
  AUTO_EN_I  in  1  enables autonomous read-out of ready peripherals.
  VALID_ADDRESS_I  in  IRLENGTH  address of ready peripheral from read interconnect, ADDR_NOP if none.
  READ_ADDRESS_O  out  IRLENGTH  address presented to read interconnect.
  READ_READY_O  out  1  read strobe to read interconnect.
  READ_VALID_I  in  1  interconnect read valid.
  READ_DATA_I  in  READ_WIDTH  interconnect read data.
  TX_VALID_O  out  1  result valid towards UART transmit path.
  TX_READY_I  in  1  transmit path accepts result.
  TX_DATA_O  out  READ_WIDTH  result data.
  TX_ADDR_O  out  IRLENGTH  address the result belongs to.
  TX_SRC_O  out  1  0 = host request, 1 = autonomous.
  TX_ERR_O  out  1  retries exhausted, TX_DATA_O is zero.
  BUSY_O  out  1  high in every state except IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, SEND.
REQ-006 Host pending SHALL be HOST_REQ_I=1; auto pending SHALL be AUTO_EN_I=1 and VALID_ADDRESS_I != ADDR_NOP.
REQ-007 In IDLE, with exactly one pending, SHALL grant it; with both pending, SHALL grant the source not granted last (round-robin via last_grant bit).
REQ-008 On grant SHALL register the granted address into READ_ADDRESS_O and TX_ADDR_O, set TX_SRC_O, update last_grant, clear retry counter, move to ISSUE.
REQ-009 HOST_ACK_O SHALL be 1 only in the cycle after a host grant (registered); host deasserting HOST_REQ_I after HOST_ACK_O is the host's duty, a held request is a new request.
REQ-010 In ISSUE READ_READY_O SHALL be 1 for exactly one cycle, then FSM moves to WAIT; READ_READY_O SHALL be 0 in all other states.
REQ-011 READ_ADDRESS_O SHALL remain stable from grant until return to IDLE.
REQ-012 WAIT SHALL last one cycle and sample READ_VALID_I: 1 -> capture READ_DATA_I into TX_DATA_O, TX_ERR_O=0, go SEND; 0 and retry count < MAX_RETRY -> increment count, go ISSUE; 0 and count = MAX_RETRY -> TX_DATA_O=0, TX_ERR_O=1, go SEND.
REQ-013 MAX_RETRY=0 SHALL mean a single attempt with no re-issue.
REQ-014 In SEND TX_VALID_O SHALL be 1 with TX_DATA_O, TX_ADDR_O, TX_SRC_O, TX_ERR_O held stable until TX_READY_I=1; on TX_VALID_O & TX_READY_I FSM SHALL return to IDLE, TX_VALID_O 0 next cycle.
REQ-015 TX_VALID_O SHALL NOT depend combinationally on TX_READY_I.
REQ-016 Requests arriving outside IDLE SHALL be ignored until IDLE; no queueing.
REQ-017 Latency, no retries, TX_READY_I=1: grant edge -> ISSUE cycle 1, WAIT cycle 2, TX_VALID_O high cycle 3, IDLE cycle 4; back-to-back grant possible from cycle 4.
REQ-018 AUTO_EN_I deasserting after an auto grant SHALL NOT abort the transaction.

Reset
REQ-019 RST_I=1 at a clock edge SHALL force IDLE from any state, including mid-ISSUE/WAIT/SEND, discarding the transaction.
REQ-020 Reset values: READ_READY_O=0, READ_ADDRESS_O=ADDR_NOP, TX_VALID_O=0, TX_DATA_O=0, TX_ADDR_O=ADDR_NOP, TX_SRC_O=0, TX_ERR_O=0, HOST_ACK_O=0, BUSY_O=0, retry count 0, last_grant=auto (host wins first tie).

Verification
REQ-021 Host read: HOST_REQ_I=1, HOST_ADDR_I=ADDR_IDCODE, READ_VALID_I=1 in WAIT, READ_DATA_I=32'h1 -> HOST_ACK_O one pulse, READ_READY_O one cycle, TX_VALID_O at cycle 3 with TX_DATA_O=32'h1, TX_SRC_O=0, TX_ERR_O=0.
REQ-022 Tie: host and auto (VALID_ADDRESS_I=ADDR_DMI) pending continuously after reset -> grants alternate host, auto, host, auto; TX_SRC_O sequence 0,1,0,1.
REQ-023 Retry exhaustion: MAX_RETRY=2, READ_VALID_I=0 always -> exactly 3 READ_READY_O pulses, then TX_VALID_O with TX_DATA_O=0, TX_ERR_O=1.
REQ-024 Backpressure: TX_READY_I=0 for 10 cycles in SEND -> TX_VALID_O and all TX_* stable 10 cycles, new requests ignored, IDLE one cycle after TX_READY_I=1.
REQ-025 Reset mid-WAIT and mid-SEND -> next cycle all outputs at REQ-020 values, no TX handshake emitted.
REQ-026 AUTO_EN_I=0 with VALID_ADDRESS_I=ADDR_STB0_CS -> no grant, BUSY_O stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared JTAG-over-UART constants: instruction register width and the read addresses.
package uart_pkg;

  localparam int unsigned IRLENGTH = 5;

  localparam logic [IRLENGTH-1:0] ADDR_IDCODE  = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h08;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h09;
  localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;
  localparam logic [IRLENGTH-1:0] ADDR_NOP     = 5'h1F;

endpackage

// File: rtl/tap_read_arbiter.sv
// Arbitrates host reads and autonomous read-out of ready peripherals onto the TAP read
// interconnect, with bounded retry on not-valid samples and a valid/ready result channel.
module tap_read_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned READ_WIDTH = 32,
  parameter int unsigned MAX_RETRY  = 15
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  HOST_REQ_I,
  input  logic [IRLENGTH-1:0]   HOST_ADDR_I,
  output logic                  HOST_ACK_O,
  input  logic                  AUTO_EN_I,
  input  logic [IRLENGTH-1:0]   VALID_ADDRESS_I,
  output logic [IRLENGTH-1:0]   READ_ADDRESS_O,
  output logic                  READ_READY_O,
  input  logic                  READ_VALID_I,
  input  logic [READ_WIDTH-1:0] READ_DATA_I,
  output logic                  TX_VALID_O,
  input  logic                  TX_READY_I,
  output logic [READ_WIDTH-1:0] TX_DATA_O,
  output logic [IRLENGTH-1:0]   TX_ADDR_O,
  output logic                  TX_SRC_O,
  output logic                  TX_ERR_O,
  output logic                  BUSY_O
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  last_auto_q, last_auto_d;
  logic [IRLENGTH-1:0]   read_addr_q, read_addr_d;
  logic                  read_ready_q, read_ready_d;
  logic                  host_ack_q, host_ack_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [READ_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [IRLENGTH-1:0]   tx_addr_q, tx_addr_d;
  logic                  tx_src_q, tx_src_d;
  logic                  tx_err_q, tx_err_d;
  logic                  busy_q, busy_d;

  logic host_pend_c;
  logic auto_pend_c;
  logic grant_host_c;
  logic grant_auto_c;

  // Round-robin: on a tie the source not granted last wins.
  always_comb begin
    host_pend_c  = HOST_REQ_I;
    auto_pend_c  = AUTO_EN_I && (VALID_ADDRESS_I != ADDR_NOP);
    grant_host_c = host_pend_c && (!auto_pend_c || last_auto_q);
    grant_auto_c = auto_pend_c && !grant_host_c;
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    last_auto_d = last_auto_q;
    read_addr_d = read_addr_q;
    host_ack_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_addr_d   = tx_addr_q;
    tx_src_d    = tx_src_q;
    tx_err_d    = tx_err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_host_c) begin
          read_addr_d = HOST_ADDR_I;
          tx_addr_d   = HOST_ADDR_I;
          tx_src_d    = 1'b0;
          last_auto_d = 1'b0;
          retry_d     = '0;
          host_ack_d  = 1'b1;
          state_d     = ST_ISSUE;
        end else if (grant_auto_c) begin
          read_addr_d = VALID_ADDRESS_I;
          tx_addr_d   = VALID_ADDRESS_I;
          tx_src_d    = 1'b1;
          last_auto_d = 1'b1;
          retry_d     = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (READ_VALID_I) begin
          tx_data_d = READ_DATA_I;
          tx_err_d  = 1'b0;
          state_d   = ST_SEND;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ST_ISSUE;
        end else begin
          tx_data_d = '0;
          tx_err_d  = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (TX_READY_I) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they align with the state itself.
    read_ready_d = (state_d == ST_ISSUE);
    tx_valid_d   = (state_d == ST_SEND);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= ST_IDLE;
      retry_q      <= '0;
      last_auto_q  <= 1'b1;
      read_addr_q  <= ADDR_NOP;
      read_ready_q <= 1'b0;
      host_ack_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_addr_q    <= ADDR_NOP;
      tx_src_q     <= 1'b0;
      tx_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      last_auto_q  <= last_auto_d;
      read_addr_q  <= read_addr_d;
      read_ready_q <= read_ready_d;
      host_ack_q   <= host_ack_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_addr_q    <= tx_addr_d;
      tx_src_q     <= tx_src_d;
      tx_err_q     <= tx_err_d;
      busy_q       <= busy_d;
    end
  end

  assign READ_ADDRESS_O = read_addr_q;
  assign READ_READY_O   = read_ready_q;
  assign HOST_ACK_O     = host_ack_q;
  assign TX_VALID_O     = tx_valid_q;
  assign TX_DATA_O      = tx_data_q;
  assign TX_ADDR_O      = tx_addr_q;
  assign TX_SRC_O       = tx_src_q;
  assign TX_ERR_O       = tx_err_q;
  assign BUSY_O         = busy_q;

endmodule

// File: tb/tb_tap_read_arbiter.sv
// Randomized self-checking bench for tap_read_arbiter: a transaction-level model predicts
// grant order, strobe counts, result data/error and handshake timing.
module tb_tap_read_arbiter;
  import uart_pkg::*;

  localparam int unsigned RW = 32;
  localparam int unsigned MR = 2;

  logic                CLK_I;
  logic                RST_I;
  logic                HOST_REQ_I;
  logic [IRLENGTH-1:0] HOST_ADDR_I;
  logic                HOST_ACK_O;
  logic                AUTO_EN_I;
  logic [IRLENGTH-1:0] VALID_ADDRESS_I;
  logic [IRLENGTH-1:0] READ_ADDRESS_O;
  logic                READ_READY_O;
  logic                READ_VALID_I;
  logic [RW-1:0]       READ_DATA_I;
  logic                TX_VALID_O;
  logic                TX_READY_I;
  logic [RW-1:0]       TX_DATA_O;
  logic [IRLENGTH-1:0] TX_ADDR_O;
  logic                TX_SRC_O;
  logic                TX_ERR_O;
  logic                BUSY_O;

  tap_read_arbiter #(.READ_WIDTH(RW), .MAX_RETRY(MR)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .HOST_REQ_I(HOST_REQ_I), .HOST_ADDR_I(HOST_ADDR_I), .HOST_ACK_O(HOST_ACK_O),
    .AUTO_EN_I(AUTO_EN_I), .VALID_ADDRESS_I(VALID_ADDRESS_I),
    .READ_ADDRESS_O(READ_ADDRESS_O), .READ_READY_O(READ_READY_O),
    .READ_VALID_I(READ_VALID_I), .READ_DATA_I(READ_DATA_I),
    .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .TX_DATA_O(TX_DATA_O),
    .TX_ADDR_O(TX_ADDR_O), .TX_SRC_O(TX_SRC_O), .TX_ERR_O(TX_ERR_O), .BUSY_O(BUSY_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;
  int rr_cnt = 0;
  int ack_cnt = 0;
  bit last_auto = 1'b1;

  // Pulse counters sampled mid-cycle.
  always @(negedge CLK_I) begin
    if (READ_READY_O) rr_cnt++;
    if (HOST_ACK_O) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic idle_inputs();
    HOST_REQ_I      = 1'b0;
    HOST_ADDR_I     = ADDR_NOP;
    AUTO_EN_I       = 1'b0;
    VALID_ADDRESS_I = ADDR_NOP;
    READ_VALID_I    = 1'b0;
    READ_DATA_I     = '0;
    TX_READY_I      = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_ready"}, 32'(READ_READY_O), 32'd0);
    check({tag, "_rd_addr"},  32'(READ_ADDRESS_O), 32'(ADDR_NOP));
    check({tag, "_tx_valid"}, 32'(TX_VALID_O), 32'd0);
    check({tag, "_tx_data"},  TX_DATA_O, 32'd0);
    check({tag, "_tx_addr"},  32'(TX_ADDR_O), 32'(ADDR_NOP));
    check({tag, "_tx_src"},   32'(TX_SRC_O), 32'd0);
    check({tag, "_tx_err"},   32'(TX_ERR_O), 32'd0);
    check({tag, "_ack"},      32'(HOST_ACK_O), 32'd0);
    check({tag, "_busy"},     32'(BUSY_O), 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_I = 1'b1;
    step();
    RST_I = 1'b0;
    last_auto = 1'b1;
  endtask

  // One complete transaction from IDLE; nfail = number of not-valid samples before a valid one.
  task automatic run_txn(input bit hreq, input logic [IRLENGTH-1:0] haddr, input bit aen,
                         input logic [IRLENGTH-1:0] vaddr, input int nfail,
                         input logic [31:0] data, input int stall);
    bit hp, ap, gh, eerr;
    logic [IRLENGTH-1:0] ea;
    logic [31:0] edata;
    int attempts, rr0, ack0;
    hp = hreq;
    ap = aen && (vaddr != ADDR_NOP);
    HOST_REQ_I = hreq; HOST_ADDR_I = haddr; AUTO_EN_I = aen; VALID_ADDRESS_I = vaddr;
    rr0 = rr_cnt; ack0 = ack_cnt;
    if (!hp && !ap) begin
      repeat (3) begin
        step();
        check("nogrant_busy", 32'(BUSY_O), 32'd0);
      end
      check("nogrant_strobes", 32'(rr_cnt - rr0 + ack_cnt - ack0), 32'd0);
      idle_inputs();
      return;
    end
    gh       = hp && (!ap || last_auto);
    ea       = gh ? haddr : vaddr;
    attempts = (nfail > int'(MR)) ? int'(MR) + 1 : nfail + 1;
    eerr     = (nfail > int'(MR));
    edata    = eerr ? 32'd0 : data;

    step();
    check("grant_ack", 32'(HOST_ACK_O), 32'(gh));
    check("grant_rd_ready", 32'(READ_READY_O), 32'd1);
    check("grant_addr", 32'(READ_ADDRESS_O), 32'(ea));
    check("grant_busy", 32'(BUSY_O), 32'd1);
    AUTO_EN_I = 1'($urandom % 2);
    for (int a = 0; a < attempts; a++) begin
      READ_VALID_I = (a == nfail);
      READ_DATA_I  = (a == nfail) ? data : $urandom;
      HOST_REQ_I   = 1'($urandom % 2);
      step();
      check("wait_rd_ready", 32'(READ_READY_O), 32'd0);
      check("wait_addr_stable", 32'(READ_ADDRESS_O), 32'(ea));
      step();
      READ_VALID_I = 1'b0;
      if (a < attempts - 1) check("reissue", 32'(READ_READY_O), 32'd1);
    end
    check("send_valid", 32'(TX_VALID_O), 32'd1);
    check("send_data", TX_DATA_O, edata);
    check("send_err", 32'(TX_ERR_O), 32'(eerr));
    check("send_src", 32'(TX_SRC_O), 32'(!gh));
    check("send_addr", 32'(TX_ADDR_O), 32'(ea));
    check("strobe_count", 32'(rr_cnt - rr0), 32'(attempts));
    for (int s = 0; s < stall; s++) begin
      TX_READY_I = 1'b0;
      HOST_REQ_I = 1'b1; HOST_ADDR_I = ADDR_IDCODE;
      AUTO_EN_I = 1'b1; VALID_ADDRESS_I = ADDR_DMI;
      step();
      check("stall_valid", 32'(TX_VALID_O), 32'd1);
      check("stall_data", TX_DATA_O, edata);
      check("stall_meta", 32'({TX_ADDR_O, TX_SRC_O, TX_ERR_O}), 32'({ea, !gh, eerr}));
      check("stall_no_strobe", 32'({READ_READY_O, HOST_ACK_O}), 32'd0);
    end
    TX_READY_I = 1'b1;
    step();
    check("done_valid", 32'(TX_VALID_O), 32'd0);
    check("done_busy", 32'(BUSY_O), 32'd0);
    check("ack_count", 32'(ack_cnt - ack0), 32'(gh));
    idle_inputs();
    last_auto = !gh;
  endtask

  // Host read interrupted by reset during WAIT or SEND.
  task automatic reset_mid(input bit in_send);
    HOST_REQ_I = 1'b1; HOST_ADDR_I = ADDR_IDCODE;
    step();
    HOST_REQ_I = 1'b0;
    step();
    if (in_send) begin
      READ_VALID_I = 1'b1; READ_DATA_I = 32'hDEAD_BEEF;
      step();
      READ_VALID_I = 1'b0;
      check("pre_reset_send", 32'(TX_VALID_O), 32'd1);
    end
    RST_I = 1'b1;
    TX_READY_I = 1'b1;
    step();
    RST_I = 1'b0;
    check_reset_vals(in_send ? "rst_send" : "rst_wait");
    idle_inputs();
    last_auto = 1'b1;
    step();
    check("post_reset_tx", 32'({TX_VALID_O, BUSY_O}), 32'd0);
  endtask

  initial begin
    logic [IRLENGTH-1:0] addrs [4];
    addrs[0] = ADDR_NOP; addrs[1] = ADDR_DMI; addrs[2] = ADDR_STB0_CS; addrs[3] = ADDR_IDCODE;
    idle_inputs();
    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    check_reset_vals("por");
    RST_I = 1'b0;

    run_txn(1'b1, ADDR_IDCODE, 1'b0, ADDR_NOP, 0, 32'h1, 0);
    do_reset();
    repeat (4) run_txn(1'b1, ADDR_IDCODE, 1'b1, ADDR_DMI, 0, $urandom, 1);
    run_txn(1'b1, ADDR_DMI, 1'b0, ADDR_NOP, 99, $urandom, 0);
    run_txn(1'b0, ADDR_NOP, 1'b1, ADDR_STB0_CS, 1, 32'hCAFE_0001, 10);
    run_txn(1'b0, ADDR_NOP, 1'b0, ADDR_STB0_CS, 0, 32'h0, 0);
    reset_mid(1'b0);
    reset_mid(1'b1);
    run_txn(1'b1, ADDR_STB1_CS, 1'b1, ADDR_DMI, 2, 32'h1234_5678, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom % 2), addrs[$urandom % 4], 1'($urandom % 2), addrs[$urandom % 4],
              int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
